// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master. It turns a valid/ready register command
// stream into AXI-Lite write and read transactions and returns one response
// for each command. Transaction counters record completed writes and reads.
module axi_lite_cmd_master #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,

    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic              busy,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              cmd_ready_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [31:0]       rsp_rdata_q;
    logic [1:0]        rsp_resp_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  rd_count_q;
    logic              busy_q;

    // A write channel counts as done if it already handshook or handshakes on this edge.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q || m_axi_wready;

    // Control FSM; every block output is a register updated here.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrReq;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRdReq;
                        end
                    end
                end
                StWrReq: begin
                    if (awvalid_q && m_axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && m_axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (m_axi_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi_bresp;
                        rsp_rdata_q <= '0;
                        rsp_write_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        wr_count_q  <= wr_count_q + CNT_W'(1);
                        state_q     <= StRsp;
                    end
                end
                StRdReq: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdResp;
                    end
                end
                StRdResp: begin
                    if (m_axi_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi_rresp;
                        rsp_rdata_q <= m_axi_rdata;
                        rsp_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rd_count_q  <= rd_count_q + CNT_W'(1);
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign wr_count      = wr_count_q;
    assign rd_count      = rd_count_q;
    assign busy          = busy_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI-Lite master that converts a simple valid/ready register command stream into AXI-Lite write and read transactions, and returns one response per command. It sits directly upstream of the AXI-Lite register slave in `top_wrapper` and drives its `s_axi_*` port set, so test sequencers and on-chip controllers can access the register file without implementing AXI handshakes.

## Interface
- `ADDR_W`, 4, AXI address width; matches the slave's `s_axi_awaddr`/`s_axi_araddr` width.
- `CNT_W`, 16, width of the completed-transaction counters.
- `aclk` input 1: clock; all logic is on the rising edge.
- `aresetn` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block accepts a command.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input ADDR_W: target address.
- `cmd_wdata` input 32: write data; ignored for reads.
- `cmd_wstrb` input 4: write byte strobes; ignored for reads.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_write` output 1: the response belongs to a write.
- `rsp_rdata` output 32: read data; 0 for writes.
- `rsp_resp` output 2: BRESP or RRESP as returned by the slave.
- `wr_count` output CNT_W: completed writes.
- `rd_count` output CNT_W: completed reads.
- `busy` output 1: state is not IDLE.
- `m_axi_awaddr` output ADDR_W, `m_axi_awvalid` output 1, `m_axi_awready` input 1.
- `m_axi_wdata` output 32, `m_axi_wstrb` output 4, `m_axi_wvalid` output 1, `m_axi_wready` input 1.
- `m_axi_bresp` input 2, `m_axi_bvalid` input 1, `m_axi_bready` output 1.
- `m_axi_araddr` output ADDR_W, `m_axi_arvalid` output 1, `m_axi_arready` input 1.
- `m_axi_rdata` input 32, `m_axi_rresp` input 2, `m_axi_rvalid` input 1, `m_axi_rready` output 1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP. All outputs are registered.
- IDLE: `cmd_ready`=1. On a command handshake:
  - Capture addr, wdata, wstrb and the write flag.
  - Write: go to WR_REQ with `awvalid`=`wvalid`=1.
  - Read: go to RD_REQ with `arvalid`=1.
- WR_REQ: `awvalid` and `wvalid` drop independently on their own handshakes (AW and W may complete in either order or the same cycle). Go to WR_RESP the cycle after both have completed.
- WR_RESP: `bready`=1. On the B handshake:
  - Latch `bresp` into `rsp_resp`; set `rsp_rdata`=0 and `rsp_write`=1.
  - Increment `wr_count`.
  - Go to RSP.
- RD_REQ: `arvalid` held until `arready`, then go to RD_RESP.
- RD_RESP: `rready`=1. On the R handshake:
  - Latch `rdata` and `rresp`; set `rsp_write`=0.
  - Increment `rd_count`.
  - Go to RSP.
- RSP: `rsp_valid`=1 with stable payload until `rsp_ready`, then IDLE.
- Address, data and strobe outputs stay constant while their valid is high. A valid never drops before its handshake.
- Counters are unsigned and wrap from all-ones to 0. A non-OKAY resp still counts as completed.
- Only one transaction is in flight at a time; no new command is accepted until the response handshake.
- Reset (async, any state), all values immediate:
  - State = IDLE; `cmd_ready`=0 during reset and 1 from the first edge after release.
  - All `m_axi_*valid`/`*ready`, `rsp_valid`, `busy` = 0.
  - Counters and all payload registers = 0.
  - A transaction in progress at reset is abandoned.

## Timing
- Command handshake at edge N: `awvalid`/`wvalid` (or `arvalid`) high in cycle N+1; `cmd_ready` low from N+1.
- Slave with zero-wait ready (both AW and W handshake at N+1): `bready` high at N+2.
- B/R handshake at edge M: `rsp_valid` high at M+1, `bready`/`rready` low at M+1.
- `rsp_ready` high with `rsp_valid` at edge K: `rsp_valid` low and `cmd_ready` high at K+1.
- Minimum write command-to-response: 3 cycles. Minimum read command-to-response: 3 cycles.
- `busy` = !IDLE, registered alongside the state.

## Test plan
- Write 0xDEADBEEF, strb 0xF, to addr 0x4, then read addr 0x4 through the real slave. Required:
  - Read response `rsp_rdata`=0xDEADBEEF, `rsp_resp`=0.
  - `wr_count`=1, `rd_count`=1.
- AW handshake stalled 3 cycles after W completes (stub slave):
  - `wvalid` drops after its handshake while `awvalid` stays high with addr stable.
  - `bready` asserts only after AW completes.
- Stub slave returns `bresp`=2'b10 and `rresp`=2'b11:
  - Responses carry those codes.
  - Both counters still increment.
- `rsp_ready` held low 5 cycles:
  - `rsp_valid` and payload stay stable.
  - `cmd_ready` stays 0 and no AXI valid asserts.
  - Next command is accepted one cycle after the response handshake.
- `CNT_W`=4, 17 back-to-back writes: `wr_count` reads 15 after write 15, 0 after write 16, 1 after write 17.
- `aresetn` asserted while `awvalid`=1 and while `rsp_valid`=1:
  - All valids and counters are 0 immediately.
  - After release, a read of 0x0 completes normally.
